// File: rtl/iq_stream_splitter.sv
// Re-pairs an interleaved I/Q word stream into parallel I/Q samples, normalises
// each word with an arithmetic right shift and buffers pairs in a small FWFT FIFO.
module iq_stream_splitter #(
  parameter int DATA_WIDTH      = 32,
  parameter int SHIFT_WIDTH     = 6,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       din_valid,
  input  logic [SHIFT_WIDTH-1:0]     shift_amt,
  input  logic                       clr,
  output logic [DATA_WIDTH-1:0]      out_I,
  output logic [DATA_WIDTH-1:0]      out_Q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic [CNT_WIDTH-1:0]       pair_cnt,
  output logic                       overflow,
  output logic                       pair_err
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;

  typedef enum logic {S_I, S_Q} state_t;

  // Shift counts past the word width saturate to DATA_WIDTH-1, which leaves
  // only the sign: 0 for non-negative words, -1 for negative ones.
  function automatic logic signed [DATA_WIDTH-1:0] norm_shift(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic [SHIFT_WIDTH-1:0]       s
  );
    int sh;
    sh = (int'(s) > DATA_WIDTH - 1) ? DATA_WIDTH - 1 : int'(s);
    return x >>> sh;
  endfunction

  state_t                        state, next_state;
  logic                          push, latch_i, err_set;
  logic                          pop, full, accept;
  logic signed [DATA_WIDTH-1:0]  word_p0;
  logic signed [DATA_WIDTH-1:0]  i_hold_p0;
  logic signed [DATA_WIDTH-1:0]  mem_i [DEPTH];
  logic signed [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]    wr_ptr, rd_ptr;

  assign word_p0 = norm_shift(din, shift_amt);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_I;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
    latch_i    = 1'b0;
    err_set    = 1'b0;
    if (clr) begin
      next_state = S_I;
    end else begin
      case (state)
        S_I: begin
          if (din_valid) begin
            latch_i    = 1'b1;
            next_state = S_Q;
          end
        end
        S_Q: begin
          // A missing Q drops the held I; the next valid word restarts as I.
          if (din_valid) push = 1'b1;
          else           err_set = 1'b1;
          next_state = S_I;
        end
        default: next_state = S_I;
      endcase
    end
  end

  assign out_valid = (fifo_level != '0);
  assign full      = (fifo_level == (FIFO_DEPTH_LOG2 + 1)'(DEPTH));
  assign pop       = out_valid && out_ready && !clr;
  assign accept    = push && (!full || pop);

  // ---- stage p0 -> FIFO: held I word and pair storage ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      i_hold_p0 <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_i[k] <= '0;
        mem_q[k] <= '0;
      end
    end else begin
      if (clr)          i_hold_p0 <= '0;
      else if (latch_i) i_hold_p0 <= word_p0;
      if (accept) begin
        mem_i[wr_ptr] <= i_hold_p0;
        mem_q[wr_ptr] <= word_p0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      pair_cnt   <= '0;
      overflow   <= 1'b0;
      pair_err   <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      pair_cnt   <= '0;
      overflow   <= 1'b0;
      pair_err   <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr   <= wr_ptr + 1'b1;
        pair_cnt <= pair_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (push && !accept) overflow <= 1'b1;
      if (err_set)         pair_err <= 1'b1;
    end
  end

  assign out_I = mem_i[rd_ptr];
  assign out_Q = mem_q[rd_ptr];

endmodule

// File: tb/tb_iq_stream_splitter.sv
// Directed self-checking bench for iq_stream_splitter with hand-computed vectors.
module tb_iq_stream_splitter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] din;
  logic        din_valid;
  logic [5:0]  shift_amt;
  logic        clr;
  logic [31:0] out_I, out_Q;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic [15:0] pair_cnt;
  logic        overflow, pair_err;

  int checks   = 0;
  int failures = 0;

  iq_stream_splitter dut (
    .CLK(CLK), .RESET(RESET), .din(din), .din_valid(din_valid),
    .shift_amt(shift_amt), .clr(clr), .out_I(out_I), .out_Q(out_Q),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
    .pair_cnt(pair_cnt), .overflow(overflow), .pair_err(pair_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic word(input logic [31:0] w);
    din = w; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] i_w, input logic [31:0] q_w);
    word(i_w);
    word(q_w);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; din = '0; din_valid = 1'b0; shift_amt = 6'd0;
    clr = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_I", out_I, 0);
    chk("rst_out_Q", out_Q, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_cnt", pair_cnt, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", pair_err, 0);
    @(negedge CLK);
    RESET = 1'b0;
    tick();

    // Basic pairing with shift 4
    shift_amt = 6'd4; out_ready = 1'b1;
    send_pair(32'h0000_0100, 32'hFFFF_FF00);
    chk("t1_valid", out_valid, 1);
    chk("t1_I", out_I, 32'h0000_0010);
    chk("t1_Q", out_Q, 32'hFFFF_FFF0);
    chk("t1_cnt", pair_cnt, 1);
    tick();
    chk("t1_drained", out_valid, 0);

    // Overflow: 5 pairs into a depth-4 FIFO with no pops
    shift_amt = 6'd0; out_ready = 1'b0;
    do_clr();
    for (int k = 1; k <= 5; k++) send_pair(32'h11 * k, 32'h22 * k);
    chk("t2_level", fifo_level, 4);
    chk("t2_ovf", overflow, 1);
    chk("t2_cnt", pair_cnt, 4);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t2_vld", out_valid, 1);
      chk("t2_I", out_I, 32'h11 * k);
      chk("t2_Q", out_Q, 32'h22 * k);
      tick();
    end
    chk("t2_empty", out_valid, 0);
    chk("t2_ovf_sticky", overflow, 1);

    // Pairing error and realignment
    do_clr();
    chk("t3_ovf_clr", overflow, 0);
    word(32'h0000_0AAA);
    tick();
    chk("t3_err", pair_err, 1);
    chk("t3_no_pair", out_valid, 0);
    send_pair(32'h5, 32'h6);
    chk("t3_vld", out_valid, 1);
    chk("t3_I", out_I, 32'h5);
    chk("t3_Q", out_Q, 32'h6);
    chk("t3_cnt", pair_cnt, 1);
    tick();

    // Full FIFO with simultaneous pop and push
    out_ready = 1'b0;
    do_clr();
    for (int k = 1; k <= 4; k++) send_pair(32'h100 + k, 32'h200 + k);
    chk("t4_full", fifo_level, 4);
    word(32'h105);
    din = 32'h205; din_valid = 1'b1; out_ready = 1'b1;
    tick();
    din_valid = 1'b0; out_ready = 1'b0;
    chk("t4_level", fifo_level, 4);
    chk("t4_ovf", overflow, 0);
    chk("t4_cnt", pair_cnt, 5);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("t4_I", out_I, 32'h100 + k);
      chk("t4_Q", out_Q, 32'h200 + k);
      tick();
    end
    chk("t4_empty", out_valid, 0);

    // Oversized shift saturates to the sign
    out_ready = 1'b0;
    do_clr();
    shift_amt = 6'd40;
    send_pair(32'h8000_0000, 32'h7FFF_FFFF);
    chk("t5_I", out_I, 32'hFFFF_FFFF);
    chk("t5_Q", out_Q, 32'h0000_0000);
    tick();
    chk("t5_hold_I", out_I, 32'hFFFF_FFFF);
    chk("t5_hold_vld", out_valid, 1);

    // clr on the same cycle as a Q word
    shift_amt = 6'd0;
    do_clr();
    word(32'h9);
    tick();
    send_pair(32'h1, 32'h2);
    send_pair(32'h3, 32'h4);
    chk("t6_pre_level", fifo_level, 2);
    chk("t6_pre_err", pair_err, 1);
    word(32'h7);
    din = 32'h8; din_valid = 1'b1; clr = 1'b1;
    tick();
    din_valid = 1'b0; clr = 1'b0;
    chk("t6_valid", out_valid, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_cnt", pair_cnt, 0);
    chk("t6_err", pair_err, 0);
    chk("t6_ovf", overflow, 0);
    tick();
    chk("t6_no_pair", out_valid, 0);

    // Asynchronous reset between an I and a Q word
    send_pair(32'hA, 32'hB);
    word(32'hC);
    RESET = 1'b1;
    #2;
    chk("t7_valid", out_valid, 0);
    chk("t7_level", fifo_level, 0);
    chk("t7_cnt", pair_cnt, 0);
    chk("t7_I", out_I, 0);
    chk("t7_Q", out_Q, 0);
    RESET = 1'b0;
    send_pair(32'h77, 32'h88);
    chk("t7_realign_I", out_I, 32'h77);
    chk("t7_realign_Q", out_Q, 32'h88);
    chk("t7_realign_cnt", pair_cnt, 1);
    chk("t7_realign_err", pair_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
